itcm_boot_ctrl: RTL and testbench
=================================

// Module: itcm_boot_ctrl
// PURPOSE
//  Boot sequencer and port arbiter for the ITCM. After reset it holds the core in reset and accepts a
//  word stream from the host or loader port. It byte-swaps each big-endian image word and writes it to
//  ITCM from word 0, then zero-fills the remaining words up to FILL_WORDS and releases the core.
//  After release, the ITCM port belongs to the core instruction-fetch path. Sits between u_srams/ITCM and cpu_top.
// PARAMETERS
//  AW          12    ITCM word-address width (depth 2**AW words)
//  FILL_WORDS  3500  words initialised (image plus zero fill); must be >=1 and <=2**AW
//  SWAP_BYTES  1     1: wdata={d[7:0],d[15:8],d[23:16],d[31:24]}; 0: wdata=d
// PORTS
//  clk          in   1   core clock; all state on rising edge
//  rst_n        in   1   synchronous active-low reset
//  start        in   1   pulse: begin load (honoured only in IDLE)
//  ld_valid     in   1   loader word valid
//  ld_ready     out  1   loader word accepted when ld_valid&&ld_ready
//  ld_data      in   32  loader word (big-endian image byte order)
//  ld_last      in   1   marks final image word
//  core_cs      in   1   core fetch request (used only in RUN)
//  core_addr    in   AW  core fetch word address
//  itcm_cs      out  1   ITCM chip select
//  itcm_we      out  1   ITCM write enable
//  itcm_wem     out  4   ITCM byte write mask
//  itcm_addr    out  AW  ITCM word address
//  itcm_wdata   out  32  ITCM write data
//  core_rst_n   out  1   core reset, active-low, registered
//  busy         out  1   in LOAD or FILL
//  done         out  1   in RUN
//  err          out  1   sticky: image hit FILL_WORDS without ld_last
// BEHAVIOUR
//  States: IDLE, LOAD, FILL, RUN. Word counter cnt has AW+1 bits.
//  Reset (rst_n=0 at an edge):
//   - state=IDLE, cnt=0.
//   - ld_ready, itcm_cs/we, wem, addr, wdata, busy, done and err are all 0.
//   - core_rst_n=0.
//   - Reset mid-LOAD/FILL/RUN aborts at once; no further ITCM writes occur.
//  IDLE: start=1 -> LOAD, cnt=0. Otherwise stay. ld_ready=0.
//  LOAD: ld_ready=1. On each handshake at cycle N, cycle N+1 drives a registered write:
//   - itcm_cs=1, itcm_we=1, itcm_wem=4'hF, itcm_addr=cnt, itcm_wdata=swap(ld_data).
//   - cnt increments at that edge.
//   - Back-to-back handshakes give one write per cycle.
//   - Handshake with cnt==FILL_WORDS-1 -> RUN. If ld_last=0 on that beat, err=1 (sticky until reset).
//     ld_ready=0 from the next cycle, so later words are never accepted.
//   - Handshake with ld_last=1 and cnt<FILL_WORDS-1 -> FILL.
//   - No handshake: itcm_cs=0 in the next cycle.
//  FILL: ld_ready=0. Each cycle writes itcm_addr=cnt, itcm_wdata=0, wem=4'hF, then cnt++.
//   - The write at cnt==FILL_WORDS-1 is the last one -> RUN.
//  RUN: itcm_we=0, itcm_wem=0, itcm_cs=core_cs, itcm_addr=core_addr (combinational passthrough).
//   - done=1. Stays in RUN until reset. start is ignored.
//  core_rst_n rises on the first edge after the final ITCM write strobe, i.e. 1 cycle after it.
//  busy=1 exactly in LOAD/FILL. In LOAD/FILL/IDLE, core_cs is ignored and the core is held in reset.
//  start in LOAD/FILL/RUN: ignored. ld_valid in IDLE/FILL/RUN: ignored, never acknowledged.
//  Total ITCM writes per boot = FILL_WORDS exactly, at addresses 0..FILL_WORDS-1 in order, no gaps.
// TESTING
//  T1 FILL_WORDS=8 image:
//   - Stimulus: start, 3 words 0x13000000,0x93000000,0xEF000000 (last on 3rd), back-to-back.
//   - Response: writes addr0..2 = 0x00000013,0x00000093,0x000000EF; addr3..7 = 0.
//   - core_rst_n=1 one cycle after the addr7 write; done=1; err=0.
//  T2 FILL_WORDS=4 overflow:
//   - Stimulus: 6 words, no ld_last.
//   - Response: 4 writes only; err=1; ld_ready=0 after the 4th beat; RUN entered.
//  T3 ld_valid throttled:
//   - Stimulus: valid every 3rd cycle.
//   - Response: itcm_cs pulses only after handshakes, addresses contiguous, no zero writes before ld_last.
//  T4 RUN arbitration:
//   - Stimulus: core_cs=1, core_addr=0x020.
//   - Response: itcm_cs=1, itcm_addr=0x020, itcm_we=0 same cycle.
//   - Stimulus: start=1 in RUN. Response: no effect.
//  T5 mid-load reset:
//   - Stimulus: rst_n=0 one edge after 2 writes.
//   - Response: next cycle itcm_cs=0, core_rst_n=0, state IDLE.
//   - Stimulus: restart. Response: rewrites from addr 0.
//  T6 SWAP_BYTES=0:
//   - Stimulus: word 0x11223344.
//   - Response: written as 0x11223344; zero fill unchanged.

Source files
------------

// File: rtl/itcm_boot_ctrl.sv
// itcm_boot_ctrl: boot sequencer and ITCM port arbiter.
// Loads a big-endian word stream into ITCM from word 0 and zero-fills up to
// FILL_WORDS. It then releases the core and hands the ITCM port to instruction fetch.
module itcm_boot_ctrl #(
    parameter int unsigned AW         = 12,
    parameter int unsigned FILL_WORDS = 3500,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    input  logic          core_cs,
    input  logic [AW-1:0] core_addr,
    output logic          itcm_cs,
    output logic          itcm_we,
    output logic [3:0]    itcm_wem,
    output logic [AW-1:0] itcm_addr,
    output logic [31:0]   itcm_wdata,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

    localparam logic [AW:0] LAST = (AW+1)'(FILL_WORDS - 1);

    state_t        state, state_nxt;
    logic [AW:0]   cnt;
    logic          wr_v;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          err_q;
    logic          rel_q;
    logic          hs;
    logic [31:0]   ld_word;

    assign hs      = (state == LOAD) && ld_valid;
    assign ld_word = SWAP_BYTES ? {ld_data[7:0], ld_data[15:8], ld_data[23:16], ld_data[31:24]}
                                : ld_data;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: the beat at the last word ends the load regardless of ld_last.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                if (hs) begin
                    if (cnt == LAST)  state_nxt = RUN;
                    else if (ld_last) state_nxt = FILL;
                end
            end
            FILL: if (cnt == LAST) state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered write strobe, word counter, sticky error and core release.
    // The final write is issued in the first RUN cycle; the release follows one edge later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            wr_v    <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            wr_v <= 1'b0;
            unique case (state)
                IDLE: if (start) cnt <= '0;
                LOAD: begin
                    if (hs) begin
                        wr_v    <= 1'b1;
                        wr_addr <= cnt[AW-1:0];
                        wr_data <= ld_word;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST && !ld_last) err_q <= 1'b1;
                    end
                end
                FILL: begin
                    wr_v    <= 1'b1;
                    wr_addr <= cnt[AW-1:0];
                    wr_data <= '0;
                    cnt     <= cnt + 1'b1;
                end
                RUN:  rel_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Output mux: a pending boot write owns the port; otherwise RUN passes core fetches through.
    always_comb begin
        ld_ready   = (state == LOAD);
        busy       = (state == LOAD) || (state == FILL);
        done       = (state == RUN);
        err        = err_q;
        core_rst_n = rel_q;
        itcm_cs    = 1'b0;
        itcm_we    = 1'b0;
        itcm_wem   = '0;
        itcm_addr  = '0;
        itcm_wdata = '0;
        if (wr_v) begin
            itcm_cs    = 1'b1;
            itcm_we    = 1'b1;
            itcm_wem   = '1;
            itcm_addr  = wr_addr;
            itcm_wdata = wr_data;
        end else if (state == RUN) begin
            itcm_cs   = core_cs;
            itcm_addr = core_addr;
        end
    end

endmodule

// File: tb/tb_itcm_boot_ctrl.sv
// Testbench for itcm_boot_ctrl: two instances (FILL_WORDS=8 with swap, FILL_WORDS=4 without)
// share one stimulus stream and are each checked against a behavioural model.
module tb_itcm_boot_ctrl;

    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst_n, start, ld_valid, ld_last, core_cs;
    logic [31:0]   ld_data;
    logic [AW-1:0] core_addr;

    logic [1:0]    o_rdy, o_cs, o_we, o_rst, o_busy, o_done, o_err;
    logic [3:0]    o_wem  [2];
    logic [AW-1:0] o_addr [2];
    logic [31:0]   o_wd   [2];

    itcm_boot_ctrl #(.AW(AW), .FILL_WORDS(8), .SWAP_BYTES(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(o_rdy[0]),
        .ld_data(ld_data), .ld_last(ld_last), .core_cs(core_cs), .core_addr(core_addr),
        .itcm_cs(o_cs[0]), .itcm_we(o_we[0]), .itcm_wem(o_wem[0]), .itcm_addr(o_addr[0]),
        .itcm_wdata(o_wd[0]), .core_rst_n(o_rst[0]), .busy(o_busy[0]), .done(o_done[0]),
        .err(o_err[0])
    );

    itcm_boot_ctrl #(.AW(AW), .FILL_WORDS(4), .SWAP_BYTES(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(o_rdy[1]),
        .ld_data(ld_data), .ld_last(ld_last), .core_cs(core_cs), .core_addr(core_addr),
        .itcm_cs(o_cs[1]), .itcm_we(o_we[1]), .itcm_wem(o_wem[1]), .itcm_addr(o_addr[1]),
        .itcm_wdata(o_wd[1]), .core_rst_n(o_rst[1]), .busy(o_busy[1]), .done(o_done[1]),
        .err(o_err[1])
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swp(input logic [31:0] d, input bit en);
        return en ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    endfunction

    // Behavioural model, one slot per instance.
    typedef enum int {M_IDLE, M_LOAD, M_FILL, M_RUN} mode_t;
    int          fw [2] = '{8, 4};
    bit          sw [2] = '{1'b1, 1'b0};
    mode_t       md [2];
    int          cnt [2];
    bit          merr [2], mrel [2], pv [2];
    int          pa [2];
    logic [31:0] pd [2];
    logic [31:0] acc [2][64];
    int          nacc [2];
    logic [31:0] wm [2][64];
    int          nw [2];

    // Model update: a handshake or fill step schedules the write seen in the following cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                md[i] = M_IDLE; cnt[i] = 0; merr[i] = 0; mrel[i] = 0; pv[i] = 0;
                nacc[i] = 0; nw[i] = 0;
            end else begin
                if (pv[i] && pa[i] == fw[i] - 1) mrel[i] = 1;
                pv[i] = 0;
                case (md[i])
                    M_IDLE: if (start) begin md[i] = M_LOAD; cnt[i] = 0; end
                    M_LOAD: if (ld_valid) begin
                        pv[i] = 1; pa[i] = cnt[i]; pd[i] = swp(ld_data, sw[i]);
                        acc[i][nacc[i]] = ld_data; nacc[i]++;
                        if (cnt[i] == fw[i] - 1) begin
                            md[i] = M_RUN;
                            if (!ld_last) merr[i] = 1;
                        end else if (ld_last) md[i] = M_FILL;
                        cnt[i]++;
                    end
                    M_FILL: begin
                        pv[i] = 1; pa[i] = cnt[i]; pd[i] = '0;
                        if (cnt[i] == fw[i] - 1) md[i] = M_RUN;
                        cnt[i]++;
                    end
                    default: ;
                endcase
            end
        end
    end

    // One clock; all outputs of both instances compared mid-cycle.
    task automatic tick();
        logic          e_cs;
        logic [AW-1:0] e_addr;
        string         s;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? "a" : "b";
            e_cs   = pv[i] ? 1'b1 : ((md[i] == M_RUN) ? core_cs : 1'b0);
            e_addr = pv[i] ? AW'(pa[i]) : ((md[i] == M_RUN) ? core_addr : '0);
            chk({s, "_ld_ready"}, 64'(o_rdy[i]), 64'(md[i] == M_LOAD));
            chk({s, "_busy"}, 64'(o_busy[i]), 64'(md[i] == M_LOAD || md[i] == M_FILL));
            chk({s, "_done"}, 64'(o_done[i]), 64'(md[i] == M_RUN));
            chk({s, "_err"}, 64'(o_err[i]), 64'(merr[i]));
            chk({s, "_core_rst_n"}, 64'(o_rst[i]), 64'(mrel[i]));
            chk({s, "_itcm_cs"}, 64'(o_cs[i]), 64'(e_cs));
            chk({s, "_itcm_we"}, 64'(o_we[i]), 64'(pv[i]));
            chk({s, "_itcm_wem"}, 64'(o_wem[i]), pv[i] ? 64'hF : 64'h0);
            chk({s, "_itcm_addr"}, 64'(o_addr[i]), 64'(e_addr));
            chk({s, "_itcm_wdata"}, 64'(o_wd[i]), pv[i] ? 64'(pd[i]) : 64'h0);
            if (o_we[i] && nw[i] < 64) begin
                wm[i][nw[i]] = o_wd[i];
                nw[i]++;
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, input int gap);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; core_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_boot();
        for (int n = 0; n < 40 && !(o_done == 2'b11 && o_rst == 2'b11); n++) tick();
        chk("boot_timeout", 64'({o_done, o_rst}), 64'hF);
    endtask

    // Whole-image check: exactly FILL_WORDS writes, accepted words first, zeros after.
    task automatic check_image();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            chk((i == 0) ? "a_write_count" : "b_write_count", 64'(nw[i]), 64'(fw[i]));
            for (int k = 0; k < fw[i]; k++) begin
                e = (k < nacc[i]) ? swp(acc[i][k], sw[i]) : 32'h0;
                chk($sformatf("%s_img%0d", (i == 0) ? "a" : "b", k), 64'(wm[i][k]), 64'(e));
            end
        end
    endtask

    task automatic random_boot(input int gmax);
        int n;
        n = $urandom_range(1, 10);
        pulse_start();
        for (int k = 1; k <= n; k++) send($urandom, k == n, $urandom_range(0, gmax));
        wait_boot();
        check_image();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        core_cs = 1'b0; core_addr = '0;
        tick();
        chk("reset_core_rst_n", 64'(o_rst), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Short image with ld_last, back-to-back beats.
        pulse_start();
        send(32'h13000000, 1'b0, 0);
        send(32'h93000000, 1'b0, 0);
        send(32'hEF000000, 1'b1, 0);
        wait_boot();
        check_image();
        chk("t1_a_word0", 64'(wm[0][0]), 64'h13);
        chk("t6_b_word0", 64'(wm[1][0]), 64'h13000000);

        // Core fetch passthrough in RUN; start ignored.
        core_cs = 1'b1; core_addr = 6'h20;
        tick();
        chk("t4_itcm_addr", 64'(o_addr[0]), 64'h20);
        start = 1'b1;
        tick();
        start = 1'b0; core_cs = 1'b0;
        tick();
        chk("t4_still_done", 64'(o_done), 64'h3);

        // Overflow: no ld_last.
        do_reset();
        pulse_start();
        for (int k = 0; k < 10; k++) send($urandom, 1'b0, 0);
        wait_boot();
        check_image();
        chk("t2_err", 64'(o_err), 64'h3);

        // Throttled valid, every third cycle.
        do_reset();
        pulse_start();
        for (int k = 1; k <= 5; k++) send($urandom, k == 5, 2);
        wait_boot();
        check_image();

        // Reset after two writes, then restart from address 0.
        do_reset();
        pulse_start();
        send($urandom, 1'b0, 0);
        send($urandom, 1'b0, 0);
        rst_n = 1'b0;
        tick();
        chk("t5_itcm_cs", 64'(o_cs), 64'h0);
        chk("t5_busy", 64'(o_busy), 64'h0);
        rst_n = 1'b1;
        tick();
        random_boot(3);

        // Randomised boots with random core traffic afterwards.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            random_boot(r % 4);
            for (int k = 0; k < 5; k++) begin
                core_cs = 1'($urandom);
                core_addr = AW'($urandom);
                tick();
            end
            core_cs = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
